truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 116 +++++++++++
 tb/tb_truth_table_sweeper.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - walks {a,b,c} through 0..7, samples y per vector, compares to a golden table
module truth_table_sweeper #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [7:0] mismatch
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] cap_q, cap_d;
    logic [7:0] mis_q, mis_d;
    logic       pass_q, pass_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            exp_q   <= 8'h00;
            cap_q   <= 8'h00;
            mis_q   <= 8'h00;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            mis_q   <= mis_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        cap_d   = cap_q;
        mis_d   = mis_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    cap_d   = 8'h00;
                    pass_d  = 1'b0;
                    idx_d   = 3'd0;
                    cnt_d   = SETTLE_C;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cap_d[idx_q] = y;
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                        cnt_d = SETTLE_C;
                    end else begin
                        // index returns to 0 so the DUT sees 000 during FINISH
                        idx_d   = 3'd0;
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (cap_q == exp_q);
                mis_d   = cap_q ^ exp_q;
                idx_d   = 3'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign a        = idx_q[2];
    assign b        = idx_q[1];
    assign c        = idx_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign captured = cap_q;
    assign mismatch = mis_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - two sweepers (SETTLE=0 on xor3, SETTLE=1 on and-or) against a timeline model
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start_s;
    logic [1:0] a_s, b_s, c_s, y_s, busy_s, done_s, pass_s;
    logic [7:0] exp_s [2];
    logic [7:0] cap_s [2];
    logic [7:0] mis_s [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .expected(exp_s[0]),
        .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .y(y_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .captured(cap_s[0]), .mismatch(mis_s[0])
    );

    truth_table_sweeper #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .expected(exp_s[1]),
        .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .y(y_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .captured(cap_s[1]), .mismatch(mis_s[1])
    );

    assign y_s[0] = a_s[0] ^ b_s[0] ^ c_s[0];
    assign y_s[1] = (a_s[1] & b_s[1]) | c_s[1];

    function automatic logic [7:0] golden(int d);
        logic [7:0] t;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            t[i] = (d == 0) ? ^v : ((v[2] & v[1]) | v[0]);
        end
        return t;
    endfunction

    function automatic int period(int d);
        return (d == 1) ? 2 : 1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: a sweep accepted at edge k is fully described by t = edge - k
    bit         m_act [2] = '{1'b0, 1'b0};
    int         m_k   [2] = '{0, 0};
    logic [7:0] m_exp [2] = '{8'h00, 8'h00};
    logic [7:0] h_cap [2] = '{8'h00, 8'h00};
    logic [7:0] h_mis [2] = '{8'h00, 8'h00};
    bit         h_pass[2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        int n, len;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_act[d]  <= 1'b0;
                m_exp[d]  <= 8'h00;
                h_cap[d]  <= 8'h00;
                h_mis[d]  <= 8'h00;
                h_pass[d] <= 1'b0;
            end
        end else begin
            n = cyc + 1;
            cyc <= n;
            for (int d = 0; d < 2; d++) begin
                len = 8 * period(d);
                if (m_act[d] && (n - m_k[d] == len + 1)) begin
                    h_cap[d]  <= golden(d);
                    h_pass[d] <= (golden(d) == m_exp[d]);
                    h_mis[d]  <= golden(d) ^ m_exp[d];
                end
                if ((!m_act[d] || (n - m_k[d] >= len + 2)) && start_s[d]) begin
                    m_act[d]  <= 1'b1;
                    m_k[d]    <= n;
                    m_exp[d]  <= exp_s[d];
                    h_cap[d]  <= 8'h00;
                    h_pass[d] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        int t, p, len;
        bit run, fin;
        logic [7:0] e_cap;
        logic [2:0] e_abc;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                p   = period(d);
                len = 8 * p;
                t   = cyc - m_k[d];
                run = m_act[d] && (t <= len);
                fin = m_act[d] && (t == len + 1);
                e_abc = (run && t < len) ? 3'(t / p) : 3'd0;
                e_cap = h_cap[d];
                if (run) begin
                    e_cap = 8'h00;
                    for (int i = 0; i < 8; i++)
                        if (p * (i + 1) <= t) e_cap[i] = golden(d)[i];
                end
                chk($sformatf("busy%0d", d), busy_s[d], run);
                chk($sformatf("done%0d", d), done_s[d], fin);
                chk($sformatf("abc%0d", d), {a_s[d], b_s[d], c_s[d]}, e_abc);
                chk($sformatf("captured%0d", d), cap_s[d], e_cap);
                chk($sformatf("pass%0d", d), pass_s[d], run ? 1'b0 : h_pass[d]);
                if (!run) chk($sformatf("mismatch%0d", d), mis_s[d], h_mis[d]);
            end
        end
    end

    task automatic go(int d, logic [7:0] e, output int k);
        @(negedge clk);
        exp_s[d]   = e;
        start_s[d] = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start_s[d] = 1'b0;
    endtask

    task automatic wait_done(int d, output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_s[d]) begin
                at = cyc;
                break;
            end
        end
        chk($sformatf("done_timeout%0d", d), (at != -1), 1'b1);
    endtask

    initial begin
        int k, at, at2;
        start_s = 2'b00;
        exp_s[0] = 8'h00;
        exp_s[1] = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset_zero%0d", d),
                {busy_s[d], done_s[d], pass_s[d], a_s[d], b_s[d], c_s[d], cap_s[d], mis_s[d]}, 0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // and-or, matching golden
        go(1, 8'hEA, k);
        wait_done(1, at);
        chk("s1_done_latency", at - k, 17);
        chk("s1_captured", cap_s[1], 8'hEA);
        chk("s1_pass", pass_s[1], 1'b1);
        chk("s1_mismatch", mis_s[1], 8'h00);

        // one-bit golden error
        go(1, 8'hEB, k);
        wait_done(1, at);
        chk("s1_bad_captured", cap_s[1], 8'hEA);
        chk("s1_bad_pass", pass_s[1], 1'b0);
        chk("s1_bad_mismatch", mis_s[1], 8'h01);

        // xor3 with zero settle
        go(0, 8'h96, k);
        wait_done(0, at);
        chk("s0_done_latency", at - k, 9);
        chk("s0_pass", pass_s[0], 1'b1);
        chk("s0_captured", cap_s[0], 8'h96);

        // start held high: no restart while busy, back-to-back sweep
        @(negedge clk);
        exp_s[1] = 8'hEA;
        start_s[1] = 1'b1;
        k = cyc + 1;
        wait_done(1, at);
        chk("held_latency", at - k, 17);
        @(negedge clk);
        start_s[1] = 1'b0;
        chk("held_restart_busy", busy_s[1], 1'b1);
        wait_done(1, at2);
        chk("held_second_latency", at2 - at, 18);
        chk("held_second_pass", pass_s[1], 1'b1);

        // async reset at index 4
        go(1, 8'hEA, k);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            if ({a_s[1], b_s[1], c_s[1]} == 3'd4) begin
                at = i;
                break;
            end
            @(negedge clk);
        end
        chk("reach_index4", (at != -1), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_zero",
            {busy_s[1], done_s[1], pass_s[1], a_s[1], b_s[1], c_s[1], cap_s[1], mis_s[1]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        go(1, 8'hEA, k);
        wait_done(1, at);
        chk("post_reset_latency", at - k, 17);
        chk("post_reset_pass", pass_s[1], 1'b1);
        chk("post_reset_captured", cap_s[1], 8'hEA);

        // expected changes mid-sweep
        go(1, 8'hEA, k);
        repeat (5) @(negedge clk);
        exp_s[1] = 8'h00;
        wait_done(1, at);
        chk("latched_pass", pass_s[1], 1'b1);
        chk("latched_mismatch", mis_s[1], 8'h00);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
